// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Constants and types shared by the 64b/66b PCS blocks.
//   DATA_WIDTH / HDR_WIDTH : parallel word width and sync header width
//   GB_SEQ_LEN             : gearbox period in cycles (32 accepts + 1 pause)
//   SYNC_DATA / SYNC_CTRL  : the two legal sync header values
//   gb_buf_t               : 66-bit gearbox residual buffer
//   gb_insert()            : places a 34-bit field above the residual bits
// -----------------------------------------------------------------------------
package pcs_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int HDR_WIDTH  = 2;
    localparam int GB_SEQ_LEN = 33;

    // Sequence value of the single stall cycle that closes every period
    localparam logic [5:0] GB_PAUSE_SEQ = 6'(GB_SEQ_LEN - 1);

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef logic [65:0] gb_buf_t;

    // Bits of base at and above offset are zero by construction, so OR is an insert
    function automatic gb_buf_t gb_insert(input gb_buf_t base,
                                          input logic [33:0] bits,
                                          input logic [5:0] offset);
        gb_buf_t field;
        field = gb_buf_t'(bits);
        return base | (field << offset);
    endfunction

endpackage

// File: rtl/tx_gearbox_if.sv
// -----------------------------------------------------------------------------
// tx_gearbox_if
// Upstream (encoder -> gearbox) word handshake.
//   tx_data            : 32-bit data word
//   tx_sync_hdr        : 2-bit sync header, used on the first word of a block
//   tx_sync_hdr_valid  : marks the first word of a block
//   tx_data_valid      : word valid
//   tx_ready           : gearbox accepts a word this cycle
// master = encoder side, slave = gearbox side.
// -----------------------------------------------------------------------------
interface tx_gearbox_if;
    import pcs_pkg::*;

    logic [DATA_WIDTH-1:0] tx_data;
    logic [HDR_WIDTH-1:0]  tx_sync_hdr;
    logic                  tx_sync_hdr_valid;
    logic                  tx_data_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_sync_hdr,
        output tx_sync_hdr_valid,
        output tx_data_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_sync_hdr,
        input  tx_sync_hdr_valid,
        input  tx_data_valid,
        output tx_ready
    );

endinterface

// File: rtl/tx_gearbox.sv
// -----------------------------------------------------------------------------
// tx_gearbox
// Packs 66-bit blocks (2-bit header + two 32-bit words) into a continuous
// 32-bit stream. 33 output words carry 16 blocks, so the upstream is stalled
// for one cycle in every 33.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   tx_if (slave)    : input words, header, valids, ready
//   o_tx_data        : packed output word, bit 0 transmitted first
//   o_tx_data_valid  : o_tx_data holds a new word
//   o_align_err      : 1-cycle pulse, header qualifier seen on the wrong phase
//   o_underrun_cnt   : saturating count of underrun cycles
//                      (present only with TX_GEARBOX_UNDERRUN_CNT_EN defined)
// Configuration macro: TX_GEARBOX_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module tx_gearbox
    import pcs_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    tx_gearbox_if.slave           tx_if,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_data_valid,
    output logic                  o_align_err
`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           o_underrun_cnt
`endif
);

    logic [5:0]  seq_cntr_r;
    logic [5:0]  pending_r;
    gb_buf_t     buf_r;

    logic [5:0]  seq_cntr_nxt_s;
    logic [5:0]  pending_nxt_s;
    gb_buf_t     merged_s;
    logic [33:0] append_s;
    logic        pause_s;
    logic        even_s;
    logic        accept_s;
    logic        emit_s;
    logic        align_err_s;

    // Ready comes straight from the sequence register: low only on the pause cycle
    assign tx_if.tx_ready = (seq_cntr_r != GB_PAUSE_SEQ);

    // Handshake decode, phase-dependent append field and next-state arithmetic
    always_comb begin
        pause_s     = (seq_cntr_r == GB_PAUSE_SEQ);
        even_s      = ~seq_cntr_r[0];
        accept_s    = ~pause_s & tx_if.tx_data_valid;
        emit_s      = accept_s | pause_s;
        align_err_s = accept_s & (tx_if.tx_sync_hdr_valid != even_s);

        // Header is inserted purely by phase so bit alignment never depends on the qualifier
        if (even_s) begin
            append_s = {tx_if.tx_data, tx_if.tx_sync_hdr};
        end else begin
            append_s = {2'b00, tx_if.tx_data};
        end

        if (accept_s) begin
            merged_s = gb_insert(buf_r, append_s, pending_r);
        end else begin
            merged_s = buf_r;
        end

        // Even accepts leave 2 extra residual bits; the pause drains the 32 accumulated
        if (pause_s) begin
            seq_cntr_nxt_s = 6'd0;
            pending_nxt_s  = pending_r - 6'd32;
        end else if (accept_s) begin
            seq_cntr_nxt_s = seq_cntr_r + 6'd1;
            if (even_s) begin
                pending_nxt_s = pending_r + 6'd2;
            end else begin
                pending_nxt_s = pending_r;
            end
        end else begin
            seq_cntr_nxt_s = seq_cntr_r;
            pending_nxt_s  = pending_r;
        end
    end

    // Sequence, residual buffer and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_cntr_r      <= 6'd0;
            pending_r       <= 6'd0;
            buf_r           <= '0;
            o_tx_data       <= 32'd0;
            o_tx_data_valid <= 1'b0;
            o_align_err     <= 1'b0;
        end else begin
            seq_cntr_r  <= seq_cntr_nxt_s;
            pending_r   <= pending_nxt_s;
            o_align_err <= align_err_s;
            if (emit_s) begin
                o_tx_data       <= merged_s[31:0];
                buf_r           <= merged_s >> 32;
                o_tx_data_valid <= 1'b1;
            end else begin
                o_tx_data_valid <= 1'b0;
            end
        end
    end

`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
    logic underrun_s;

    // Underrun: the gearbox could take a word but none is offered
    assign underrun_s = ~pause_s & ~tx_if.tx_data_valid;

    // Saturating underrun counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_underrun_cnt <= 16'd0;
        end else if (underrun_s && (o_underrun_cnt != 16'hFFFF)) begin
            o_underrun_cnt <= o_underrun_cnt + 16'd1;
        end else begin
            o_underrun_cnt <= o_underrun_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_tx_gearbox
// Self-checking bench for tx_gearbox. The reference is a bit queue: every
// accepted word pushes its bits (header first on even words), every emitted
// output word pops 32 bits. One stall cycle follows every 32 accepted words.
// -----------------------------------------------------------------------------
module tb_tx_gearbox;
    import pcs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tx_gearbox_if gb_if();

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_err;
`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] out_ucnt;
`endif

    tx_gearbox dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .tx_if           (gb_if),
        .o_tx_data       (out_data),
        .o_tx_data_valid (out_valid),
        .o_align_err     (out_err)
`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt  (out_ucnt)
`endif
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model state
    bit          exp_q[$];
    int          period_words;
    logic [31:0] last_data;
    int          ucnt_exp;

    // Results of the latest drive_cycle
    logic        c_acc, c_rdy_seen, c_rdy_exp, c_ov_exp, c_err_exp;
    logic [31:0] c_od_exp;

    task automatic model_reset();
        exp_q.delete();
        period_words = 0;
        last_data    = 32'd0;
        ucnt_exp     = 0;
    endtask

    // Drives one cycle of input (called at posedge+1) and advances the model
    task automatic drive_cycle(input logic v, input logic hv,
                               input logic [1:0] h, input logic [31:0] d);
        logic pause;
        gb_if.tx_data_valid     = v;
        gb_if.tx_sync_hdr_valid = hv;
        gb_if.tx_sync_hdr       = h;
        gb_if.tx_data           = d;
        #1;
        c_rdy_seen = gb_if.tx_ready;
        pause      = (period_words == 32);
        c_rdy_exp  = !pause;
        c_acc      = c_rdy_exp && v;
        c_err_exp  = 1'b0;
        if (c_acc) begin
            if (period_words % 2 == 0) begin
                exp_q.push_back(h[0]);
                exp_q.push_back(h[1]);
            end
            for (int i = 0; i < 32; i++) exp_q.push_back(d[i]);
            c_err_exp = (hv != (period_words % 2 == 0));
            period_words++;
        end else if (pause) begin
            period_words = 0;
        end else begin
            if (ucnt_exp < 65535) ucnt_exp++;
        end
        if (c_acc || pause) begin
            for (int i = 0; i < 32; i++) c_od_exp[i] = exp_q.pop_front();
            last_data = c_od_exp;
            c_ov_exp  = 1'b1;
        end else begin
            c_od_exp = last_data;
            c_ov_exp = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        gb_if.tx_data_valid     = 1'b0;
        gb_if.tx_sync_hdr_valid = 1'b0;
        gb_if.tx_sync_hdr       = 2'b00;
        gb_if.tx_data           = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        gb_if.tx_data_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        assert_cnt++;
        if ({gb_if.tx_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            fail_cnt++;
            $display("FAIL reset_state got rdy/vld/err/data=%b/%b/%b/%h exp=1/0/0/00000000",
                     gb_if.tx_ready, out_valid, out_err, out_data);
        end
        apply_reset();
        assert_cnt++;
        if ({gb_if.tx_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            fail_cnt++;
            $display("FAIL reset_release got rdy/vld/err/data=%b/%b/%b/%h exp=1/0/0/00000000",
                     gb_if.tx_ready, out_valid, out_err, out_data);
        end
    endtask

    task automatic test_basic_pack();
        apply_reset();
        drive_cycle(1'b1, 1'b1, SYNC_CTRL, 32'hAAAAAAAA);
        assert_cnt++;
        if (out_data !== 32'hAAAAAAA9 || out_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL basic_word0 got %h/%b exp AAAAAAA9/1", out_data, out_valid);
        end
        drive_cycle(1'b1, 1'b0, 2'b11, 32'h55555555);
        assert_cnt++;
        if (out_data !== 32'h55555556 || out_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL basic_word1 got %h/%b exp 55555556/1", out_data, out_valid);
        end
    endtask

    task automatic test_full_period();
        int words = 0, low_cnt = 0, low_idx = -1, vcnt = 0;
        logic [31:0] d;
        apply_reset();
        for (int cyc = 0; cyc < 33; cyc++) begin
            d = 32'(words + 1) * 32'h01010101;
            drive_cycle(1'b1, (words % 2 == 0), ((words / 2) % 2 == 1) ? SYNC_CTRL : SYNC_DATA, d);
            if (!c_rdy_seen) begin low_cnt++; low_idx = cyc; end
            if (out_valid) vcnt++;
            if (c_acc) words++;
            assert_cnt++;
            if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                fail_cnt++;
                $display("FAIL full_period cyc=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", cyc,
                         c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
            end
        end
        assert_cnt++;
        if (low_cnt != 1 || low_idx != 32) begin
            fail_cnt++;
            $display("FAIL full_period_ready_low got count=%0d at=%0d exp count=1 at=32", low_cnt, low_idx);
        end
        assert_cnt++;
        if (vcnt != 33) begin
            fail_cnt++;
            $display("FAIL full_period_valid_count got %0d exp 33", vcnt);
        end
        // No residue crosses the period boundary: next block starts clean
        d = 32'h12345679;
        drive_cycle(1'b1, 1'b1, SYNC_DATA, d);
        assert_cnt++;
        if (out_data !== {d[29:0], SYNC_DATA}) begin
            fail_cnt++;
            $display("FAIL full_period_wrap got %h exp %h", out_data, {d[29:0], SYNC_DATA});
        end
    endtask

    task automatic test_underrun();
        int words = 0, gap_low = 0;
        logic v;
        apply_reset();
        for (int cyc = 0; cyc < 37; cyc++) begin
            v = !(cyc >= 5 && cyc < 8);
            drive_cycle(v, (words % 2 == 0), SYNC_DATA, $urandom());
            if (!v && !out_valid) gap_low++;
            if (c_acc) words++;
            assert_cnt++;
            if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                fail_cnt++;
                $display("FAIL underrun cyc=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", cyc,
                         c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
            end
        end
        assert_cnt++;
        if (gap_low != 3) begin
            fail_cnt++;
            $display("FAIL underrun_gap got %0d idle outputs exp 3", gap_low);
        end
`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
        assert_cnt++;
        if (out_ucnt !== 16'd3) begin
            fail_cnt++;
            $display("FAIL underrun_cnt got %0d exp 3", out_ucnt);
        end
`endif
    endtask

    task automatic test_misalign();
        logic hv_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int err_cnt = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, hv_pat[i], SYNC_CTRL, $urandom());
            if (out_err) err_cnt++;
            assert_cnt++;
            if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                fail_cnt++;
                $display("FAIL misalign w=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", i,
                         c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
            end
        end
        drive_cycle(1'b0, 1'b1, SYNC_CTRL, 32'd0);
        if (out_err) err_cnt++;
        assert_cnt++;
        if (err_cnt != 2) begin
            fail_cnt++;
            $display("FAIL misalign_pulses got %0d exp 2", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 17; i++) drive_cycle(1'b1, (i % 2 == 0), SYNC_DATA, $urandom());
        gb_if.tx_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        assert_cnt++;
        if ({gb_if.tx_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            fail_cnt++;
            $display("FAIL reset_mid_clear got rdy/vld/err/data=%b/%b/%b/%h exp=1/0/0/00000000",
                     gb_if.tx_ready, out_valid, out_err, out_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d = $urandom();
        drive_cycle(1'b1, 1'b1, SYNC_CTRL, d);
        assert_cnt++;
        if (out_data !== {d[29:0], SYNC_CTRL} || out_valid !== 1'b1 || out_err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid_first got %h/%b/%b exp %h/1/0", out_data, out_valid, out_err, {d[29:0], SYNC_CTRL});
        end
    endtask

    task automatic test_long_run();
        int gaps, tries, rdy_cnt, wpar;
        logic hv;
        logic [1:0] h;
        logic [31:0] d;
        apply_reset();
        for (int blk = 0; blk < 10000; blk++) begin
            h = 2'($urandom_range(0, 3));
            for (int w = 0; w < 2; w++) begin
                gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                for (int g = 0; g < gaps; g++) begin
                    drive_cycle(1'b0, 1'($urandom()), 2'($urandom()), $urandom());
                    assert_cnt++;
                    if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                        fail_cnt++;
                        $display("FAIL long_gap blk=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", blk,
                                 c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
                    end
                end
                hv = (w == 0);
                if ($urandom_range(0, 127) == 0) hv = !hv;
                d = $urandom();
                tries = 0;
                do begin
                    drive_cycle(1'b1, hv, h, d);
                    tries++;
                    assert_cnt++;
                    if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                        fail_cnt++;
                        $display("FAIL long_word blk=%0d w=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", blk, w,
                                 c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
                    end
                end while (!c_acc && tries < 3);
                if (!c_acc) begin
                    assert_cnt++;
                    fail_cnt++;
                    $display("FAIL long_accept_timeout blk=%0d w=%0d got no accept in 3 cycles exp accept", blk, w);
                end
            end
        end
`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
        assert_cnt++;
        if (out_ucnt !== 16'(ucnt_exp)) begin
            fail_cnt++;
            $display("FAIL long_underrun_cnt got %0d exp %0d", out_ucnt, ucnt_exp);
        end
`endif
        // Saturated input: ready duty must be exactly 32 of every 33 cycles
        rdy_cnt = 0;
        wpar = 0;
        for (int cyc = 0; cyc < 330; cyc++) begin
            drive_cycle(1'b1, (wpar == 0), SYNC_DATA, $urandom());
            if (c_rdy_seen) rdy_cnt++;
            if (c_acc) wpar = 1 - wpar;
            assert_cnt++;
            if ({c_rdy_seen, out_valid, out_err, out_data} !== {c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp}) begin
                fail_cnt++;
                $display("FAIL saturated cyc=%0d got rdy/vld/err/data=%b/%b/%b/%h exp=%b/%b/%b/%h", cyc,
                         c_rdy_seen, out_valid, out_err, out_data, c_rdy_exp, c_ov_exp, c_err_exp, c_od_exp);
            end
        end
        assert_cnt++;
        if (rdy_cnt != 320) begin
            fail_cnt++;
            $display("FAIL ready_duty got %0d of 330 exp 320", rdy_cnt);
        end
    endtask

    initial begin
        gb_if.tx_data_valid     = 1'b0;
        gb_if.tx_sync_hdr_valid = 1'b0;
        gb_if.tx_sync_hdr       = 2'b00;
        gb_if.tx_data           = 32'd0;
        model_reset();
        test_reset();
        test_basic_pack();
        test_full_period();
        test_underrun();
        test_misalign();
        test_reset_mid();
        test_long_run();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
